timer_interrupt_controller: RTL and testbench

Arbitrates pending timer interrupt flags against their mask bits and the global interrupt enable, then runs the AVR-style interrupt entry sequence: stall fetch, push the return PC onto the stack, clear the global I bit, clear the serviced flag and redirect the program counter to the vector. It sits between the timer blocks (joint TIFR/TIMSK outputs) and the program memory (PC overwrite/hold), with a side port into the stack-write path of the data memory.

---
 rtl/atmega32a_pkg.sv | 53 +++++
 rtl/timer_interrupt_controller_if.sv | 48 ++++
 rtl/priority_encoder_8.sv | 24 ++
 rtl/timer_interrupt_controller.sv | 168 ++++++++++++++++
 tb/tb_timer_interrupt_controller.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/atmega32a_pkg.sv
// Shared types and constants for the timer interrupt controller.
// Contents: entry-sequence state enum, TIFR bit positions, vector constants,
// source count / index width (widened when EXT_INT_EN is defined) and the
// index -> vector mapping function.
package atmega32a_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUSH_L,
        ST_PUSH_H,
        ST_JUMP
    } state_e;

    // TIFR / TIMSK bit positions
    localparam int unsigned TOV0_BIT  = 0;
    localparam int unsigned OCF0_BIT  = 1;
    localparam int unsigned TOV1_BIT  = 2;
    localparam int unsigned OCF1B_BIT = 3;
    localparam int unsigned OCF1A_BIT = 4;
    localparam int unsigned ICF1_BIT  = 5;
    localparam int unsigned TOV2_BIT  = 6;
    localparam int unsigned OCF2_BIT  = 7;

    localparam int unsigned VEC_W = 14;

    localparam logic [VEC_W-1:0] VEC_BASE_DEF = 14'h008;
    localparam logic [VEC_W-1:0] INT0_VEC     = 14'h002;
    localparam logic [VEC_W-1:0] INT1_VEC     = 14'h004;
    localparam logic [VEC_W-1:0] INT2_VEC     = 14'h006;

`ifdef EXT_INT_EN
    // Index 10 = INT0, 9 = INT1, 8 = INT2, 7..0 = TIFR bits.
    localparam int unsigned SRC_N = 11;
    localparam int unsigned IDX_W = 4;
`else
    localparam int unsigned SRC_N = 8;
    localparam int unsigned IDX_W = 3;
`endif

    // Map a winning source index onto its word vector address.
    function automatic logic [VEC_W-1:0] vec_of(input logic [3:0] idx,
                                                 input logic [VEC_W-1:0] base);
        logic [VEC_W-1:0] v;
        case (idx)
            4'd10:   v = INT0_VEC;
            4'd9:    v = INT1_VEC;
            4'd8:    v = INT2_VEC;
            default: v = base + VEC_W'((4'(OCF2_BIT) - idx) << 1);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/timer_interrupt_controller_if.sv
// Bus between the interrupt controller and the core / timers / stack path.
// master: controller side (drives hold, pc_*, stack_*, i_*, tifr_clear, busy).
// slave : core side (drives tifr, timsk, sreg_i, instr_boundary, pc_return, reti).
// EXT_INT_EN adds ext_flags/ext_mask inputs and ext_clear output.
interface timer_interrupt_controller_if #(
    parameter int unsigned PC_WIDTH = 14
);
    logic [7:0]          tifr;
    logic [7:0]          timsk;
    logic                sreg_i;
    logic                instr_boundary;
    logic [PC_WIDTH-1:0] pc_return;
    logic                reti;
    logic                hold;
    logic                pc_overwrite;
    logic [PC_WIDTH-1:0] pc_new;
    logic                stack_we;
    logic [7:0]          stack_data;
    logic                i_clear;
    logic                i_set;
    logic [7:0]          tifr_clear;
    logic                busy;
`ifdef EXT_INT_EN
    logic [2:0]          ext_flags;
    logic [2:0]          ext_mask;
    logic [2:0]          ext_clear;
`endif

    modport master (
        input  tifr, timsk, sreg_i, instr_boundary, pc_return, reti,
`ifdef EXT_INT_EN
        input  ext_flags, ext_mask,
        output ext_clear,
`endif
        output hold, pc_overwrite, pc_new, stack_we, stack_data,
        output i_clear, i_set, tifr_clear, busy
    );

    modport slave (
        output tifr, timsk, sreg_i, instr_boundary, pc_return, reti,
`ifdef EXT_INT_EN
        output ext_flags, ext_mask,
        input  ext_clear,
`endif
        input  hold, pc_overwrite, pc_new, stack_we, stack_data,
        input  i_clear, i_set, tifr_clear, busy
    );
endinterface

// File: rtl/priority_encoder_8.sv
// Fixed-priority encoder: highest set request bit wins.
// Ports: req (SRC_N pending sources), valid_c (any pending), index_c (winner).
// SRC_N is 8 by default and 11 with EXT_INT_EN.
module priority_encoder_8
    import atmega32a_pkg::*;
(
    input  logic [SRC_N-1:0] req,
    output logic             valid_c,
    output logic [IDX_W-1:0] index_c
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        valid_c = 1'b0;
        index_c = '0;
        for (int unsigned i = 0; i < SRC_N; i++) begin
            if (req[i]) begin
                valid_c = 1'b1;
                index_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/timer_interrupt_controller.sv
// AVR-style timer interrupt entry: arbitrate tifr & timsk under SREG.I, then
// push the return PC (low, high), clear I, clear the serviced flag and jump.
// Ports: sysClock, rst (sync, active-high), bus (timer_interrupt_controller_if.master).
// All bus outputs are registered decodes of the next state.
// Optional EXT_INT_EN: INT0..2 sources that outrank the timers.
module timer_interrupt_controller
    import atmega32a_pkg::*;
#(
    parameter int unsigned      PC_WIDTH = 14,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic                         sysClock,
    input  logic                         rst,
    timer_interrupt_controller_if.master bus
);

    logic [SRC_N-1:0]    pending;
    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                block_q;
    logic                start;

    logic                hold_q, hold_d;
    logic                stack_we_q, stack_we_d;
    logic [7:0]          stack_data_q, stack_data_d;
    logic                pc_overwrite_q, pc_overwrite_d;
    logic [PC_WIDTH-1:0] pc_new_q, pc_new_d;
    logic                i_clear_q, i_clear_d;
    logic                i_set_q, i_set_d;
    logic [7:0]          tifr_clear_q, tifr_clear_d;
    logic                busy_q, busy_d;

`ifdef EXT_INT_EN
    logic [2:0]          ext_clear_q, ext_clear_d;
    assign pending = {bus.ext_flags[0] & bus.ext_mask[0],
                      bus.ext_flags[1] & bus.ext_mask[1],
                      bus.ext_flags[2] & bus.ext_mask[2],
                      bus.tifr & bus.timsk};
    assign bus.ext_clear = ext_clear_q;
`else
    assign pending = bus.tifr & bus.timsk;
`endif

    priority_encoder_8 u_prio (
        .req     (pending),
        .valid_c (win_valid),
        .index_c (win_idx)
    );

    // A reti coincident with its own boundary suppresses entry directly; a reti
    // seen ahead of its boundary leaves block set until that boundary passes.
    assign start = (state_q == ST_IDLE) && bus.instr_boundary && bus.sreg_i &&
                   win_valid && !block_q && !bus.reti;

    // Next state, latched request and registered output decode.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        idx_d          = idx_q;
        hold_d         = 1'b0;
        stack_we_d     = 1'b0;
        stack_data_d   = 8'h00;
        pc_overwrite_d = 1'b0;
        pc_new_d       = '0;
        i_clear_d      = 1'b0;
        i_set_d        = bus.reti;
        tifr_clear_d   = 8'h00;
        busy_d         = 1'b0;
`ifdef EXT_INT_EN
        ext_clear_d    = 3'b000;
`endif

        case (state_q)
            ST_IDLE:   if (start) state_d = ST_PUSH_L;
            ST_PUSH_L: state_d = ST_PUSH_H;
            ST_PUSH_H: state_d = ST_JUMP;
            ST_JUMP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (start) begin
            pc_d  = bus.pc_return;
            idx_d = win_idx;
        end

        case (state_d)
            ST_PUSH_L: begin
                hold_d       = 1'b1;
                stack_we_d   = 1'b1;
                stack_data_d = pc_d[7:0];
                busy_d       = 1'b1;
            end
            ST_PUSH_H: begin
                hold_d       = 1'b1;
                stack_we_d   = 1'b1;
                stack_data_d = 8'(pc_d >> 8);
                busy_d       = 1'b1;
            end
            ST_JUMP: begin
                hold_d         = 1'b1;
                pc_overwrite_d = 1'b1;
                pc_new_d       = PC_WIDTH'(vec_of(4'(idx_d), VEC_BASE));
                i_clear_d      = 1'b1;
                // External indices (>= 8) shift out, leaving the timer clear at 0.
                tifr_clear_d   = 8'(16'd1 << idx_d);
                busy_d         = 1'b1;
`ifdef EXT_INT_EN
                if (idx_d >= 4'd8) ext_clear_d = 3'(3'd1 << (4'd10 - idx_d));
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysClock) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            idx_q          <= '0;
            block_q        <= 1'b0;
            hold_q         <= 1'b0;
            stack_we_q     <= 1'b0;
            stack_data_q   <= 8'h00;
            pc_overwrite_q <= 1'b0;
            pc_new_q       <= '0;
            i_clear_q      <= 1'b0;
            i_set_q        <= 1'b0;
            tifr_clear_q   <= 8'h00;
            busy_q         <= 1'b0;
`ifdef EXT_INT_EN
            ext_clear_q    <= 3'b000;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            idx_q          <= idx_d;
            if (bus.reti && !bus.instr_boundary) block_q <= 1'b1;
            else if (bus.instr_boundary)         block_q <= 1'b0;
            hold_q         <= hold_d;
            stack_we_q     <= stack_we_d;
            stack_data_q   <= stack_data_d;
            pc_overwrite_q <= pc_overwrite_d;
            pc_new_q       <= pc_new_d;
            i_clear_q      <= i_clear_d;
            i_set_q        <= i_set_d;
            tifr_clear_q   <= tifr_clear_d;
            busy_q         <= busy_d;
`ifdef EXT_INT_EN
            ext_clear_q    <= ext_clear_d;
`endif
        end
    end

    assign bus.hold         = hold_q;
    assign bus.stack_we     = stack_we_q;
    assign bus.stack_data   = stack_data_q;
    assign bus.pc_overwrite = pc_overwrite_q;
    assign bus.pc_new       = pc_new_q;
    assign bus.i_clear      = i_clear_q;
    assign bus.i_set        = i_set_q;
    assign bus.tifr_clear   = tifr_clear_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// Self-checking bench for timer_interrupt_controller: directed scenarios plus
// randomized entries checked against a priority/vector reference model.
module tb_timer_interrupt_controller;

    localparam int unsigned PCW = 14;

    logic sysClock = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 sysClock = ~sysClock;

    timer_interrupt_controller_if #(.PC_WIDTH(PCW)) bus ();

    timer_interrupt_controller #(
        .PC_WIDTH (PCW),
        .VEC_BASE (14'h008)
    ) dut (
        .sysClock (sysClock),
        .rst      (rst),
        .bus      (bus)
    );

    // Reference model: highest pending bit wins, vector = 8 + 2*(7 - bit).
    function automatic int ref_winner(input logic [7:0] f, input logic [7:0] m);
        for (int b = 7; b >= 0; b--) begin
            if (f[b] && m[b]) return b;
        end
        return -1;
    endfunction

    function automatic logic [13:0] ref_vector(input int b);
        return 14'(8 + 2 * (7 - b));
    endfunction

    task automatic step();
        @(posedge sysClock);
        #1;
    endtask

    // Called in cycle +1 (just after the boundary edge); walks cycles +1..+4.
    task automatic expect_entry(input int b, input logic [13:0] pc, input string tag);
        logic [4:0]  ctl;
        logic [7:0]  one;
        logic [7:0]  exp_clr;
        one     = 8'd1;
        exp_clr = one << b;

        ctl = {bus.hold, bus.stack_we, bus.pc_overwrite, bus.i_clear, bus.busy};
        checks++;
        if (ctl !== 5'b11001 || bus.stack_data !== pc[7:0]) begin
            errors++;
            $display("FAIL %s push_l: ctl=%b data=%h expected ctl=11001 data=%h", tag, ctl, bus.stack_data, pc[7:0]);
        end
        step();
        ctl = {bus.hold, bus.stack_we, bus.pc_overwrite, bus.i_clear, bus.busy};
        checks++;
        if (ctl !== 5'b11001 || bus.stack_data !== {2'b00, pc[13:8]}) begin
            errors++;
            $display("FAIL %s push_h: ctl=%b data=%h expected ctl=11001 data=%h", tag, ctl, bus.stack_data, {2'b00, pc[13:8]});
        end
        step();
        ctl = {bus.hold, bus.stack_we, bus.pc_overwrite, bus.i_clear, bus.busy};
        checks++;
        if (ctl !== 5'b10111 || bus.pc_new !== ref_vector(b) || bus.tifr_clear !== exp_clr) begin
            errors++;
            $display("FAIL %s jump: ctl=%b pc_new=%h clr=%h expected ctl=10111 pc_new=%h clr=%h",
                     tag, ctl, bus.pc_new, bus.tifr_clear, ref_vector(b), exp_clr);
        end
        step();
        ctl = {bus.hold, bus.stack_we, bus.pc_overwrite, bus.i_clear, bus.busy};
        checks++;
        if (ctl !== 5'b00000 || bus.tifr_clear !== 8'h00) begin
            errors++;
            $display("FAIL %s idle: ctl=%b clr=%h expected ctl=00000 clr=00", tag, ctl, bus.tifr_clear);
        end
    endtask

    task automatic boundary(input logic [13:0] pc);
        bus.pc_return      = pc;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] all_out;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        all_out = {bus.hold, bus.stack_we, bus.stack_data, bus.pc_overwrite, bus.pc_new,
                   bus.i_clear, bus.i_set, bus.tifr_clear, bus.busy};
        checks++;
        if (all_out !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_single();
        bus.tifr = 8'h01; bus.timsk = 8'h01; bus.sreg_i = 1'b1;
        boundary(14'h0123);
        expect_entry(0, 14'h0123, "single");
        bus.tifr = 8'h00;
        step();
    endtask

    task automatic test_priority();
        bus.tifr = 8'h12; bus.timsk = 8'hFF; bus.sreg_i = 1'b1;
        boundary(14'h2A5C);
        expect_entry(4, 14'h2A5C, "priority");
        bus.tifr = 8'h00;
        step();
    endtask

    task automatic test_gating();
        logic [10:0] act;
        for (int i = 0; i < 20; i++) begin
            bus.tifr   = 8'hFF;
            bus.sreg_i = (i < 10) ? 1'b0 : 1'b1;
            bus.timsk  = (i < 10) ? 8'hFF : 8'h00;
            boundary(14'(i * 37));
            act = {bus.hold, bus.stack_we, bus.busy, bus.tifr_clear};
            step();
            act = act | {bus.hold, bus.stack_we, bus.busy, bus.tifr_clear};
            checks++;
            if (act !== 11'd0) begin
                errors++;
                $display("FAIL gating[%0d]: activity=%h expected 0", i, act);
            end
        end
        bus.tifr = 8'h00;
    endtask

    task automatic test_reti();
        bus.tifr = 8'h01; bus.timsk = 8'h01; bus.sreg_i = 1'b1;
        // reti together with boundary: no entry, i_set next cycle
        bus.reti = 1'b1; bus.instr_boundary = 1'b1; bus.pc_return = 14'h0040;
        step();
        bus.reti = 1'b0; bus.instr_boundary = 1'b0;
        checks++;
        if (bus.i_set !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reti_coincident: i_set=%b busy=%b expected i_set=1 busy=0", bus.i_set, bus.busy);
        end
        step();
        checks++;
        if (bus.i_set !== 1'b0) begin
            errors++;
            $display("FAIL reti_iset_width: i_set=%b expected 0", bus.i_set);
        end
        boundary(14'h0041);
        expect_entry(0, 14'h0041, "reti_following");
        // reti ahead of its boundary: that boundary is blocked, the next enters
        bus.reti = 1'b1;
        step();
        bus.reti = 1'b0;
        boundary(14'h0050);
        checks++;
        if (bus.busy !== 1'b0 || bus.stack_we !== 1'b0) begin
            errors++;
            $display("FAIL reti_block: busy=%b stack_we=%b expected 0 0", bus.busy, bus.stack_we);
        end
        boundary(14'h0051);
        expect_entry(0, 14'h0051, "reti_after_block");
        bus.tifr = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        bus.tifr = 8'h04; bus.timsk = 8'hFF; bus.sreg_i = 1'b1;
        boundary(14'h1111);
        step();
        checks++;
        if (bus.stack_we !== 1'b1 || bus.stack_data !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid_push_h: stack_we=%b data=%h expected 1 11", bus.stack_we, bus.stack_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.hold, bus.stack_we, bus.stack_data, bus.pc_overwrite, bus.pc_new,
             bus.i_clear, bus.i_set, bus.tifr_clear, bus.busy} !== 36'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: hold=%b we=%b ovw=%b clr=%h busy=%b expected all 0",
                     bus.hold, bus.stack_we, bus.pc_overwrite, bus.tifr_clear, bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.pc_overwrite !== 1'b0 || bus.busy !== 1'b0 || bus.tifr_clear !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid_after[%0d]: ovw=%b busy=%b clr=%h expected 0 0 00",
                         i, bus.pc_overwrite, bus.busy, bus.tifr_clear);
            end
        end
        bus.tifr = 8'h00;
    endtask

    task automatic test_flag_during_service();
        bus.tifr = 8'h80; bus.timsk = 8'hFF; bus.sreg_i = 1'b1;
        boundary(14'h0300);
        bus.tifr = 8'h81;
        expect_entry(7, 14'h0300, "flag_during");
        bus.tifr = 8'h01;
        boundary(14'h0008);
        expect_entry(0, 14'h0008, "flag_next");
        bus.tifr = 8'h00;
        step();
    endtask

    task automatic test_back_to_back();
        bus.tifr = 8'h06; bus.timsk = 8'hFF; bus.sreg_i = 1'b1;
        boundary(14'h0A0A);
        expect_entry(2, 14'h0A0A, "b2b_first");
        bus.tifr = 8'h02;
        boundary(14'h000A);
        expect_entry(1, 14'h000A, "b2b_second");
        bus.tifr = 8'h00;
        step();
    endtask

    task automatic test_random();
        logic [7:0]  f, m;
        logic        s;
        logic [13:0] pc;
        int          w;
        for (int t = 0; t < 40; t++) begin
            f  = 8'($urandom);
            m  = 8'($urandom);
            s  = ($urandom_range(0, 3) != 0);
            pc = 14'($urandom);
            bus.tifr = f; bus.timsk = m; bus.sreg_i = s;
            boundary(pc);
            w = s ? ref_winner(f, m) : -1;
            if (w >= 0) begin
                expect_entry(w, pc, "random");
            end else begin
                checks++;
                if (bus.busy !== 1'b0 || bus.stack_we !== 1'b0 || bus.tifr_clear !== 8'h00) begin
                    errors++;
                    $display("FAIL random_noentry[%0d]: busy=%b we=%b clr=%h expected 0 0 00",
                             t, bus.busy, bus.stack_we, bus.tifr_clear);
                end
            end
            bus.tifr = 8'h00;
            step();
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.tifr           = 8'h00;
        bus.timsk          = 8'h00;
        bus.sreg_i         = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.pc_return      = '0;
        bus.reti           = 1'b0;
`ifdef EXT_INT_EN
        bus.ext_flags      = 3'b000;
        bus.ext_mask       = 3'b000;
`endif
        test_reset();
        test_single();
        test_priority();
        test_gating();
        test_reti();
        test_reset_mid();
        test_flag_during_service();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
